// File: rtl/spi_pkg.sv
// spi_pkg: SPI master/slave shared state encoding and {CPOL,CPHA} mode constants
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
endpackage

// File: rtl/spi_sck_tick.sv
// spi_sck_tick: DIV-cycle divider emitting a one-cycle tick at the end of each SCK half-period
module spi_sck_tick #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && cnt_q == LAST;
  // count cycles within a half-period, wrapping at DIV-1 and held at zero while cleared
  always_comb begin
    cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
  end
  // divider state register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master.sv
// spi_master: MSB-first full-duplex SPI master; SPI_MASTER_SDI_SYNC_EN adds a 2-flop sdi_i synchronizer
module spi_master #(
  parameter int IO_COUNT = 16,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int DIV      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [IO_COUNT-1:0] data_i,
  output logic [IO_COUNT-1:0] data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                nss_o,
  output logic                sck_o,
  output logic                sdo_o,
  input  logic                sdi_i
);
  import spi_pkg::*;
  localparam int HW = $clog2(2 * IO_COUNT + 1);
  localparam logic [HW-1:0] HLAST = HW'(2 * IO_COUNT - 1);
  localparam logic [1:0] MODE = {CPOL, CPHA};
  localparam bit POL = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
  localparam bit PHA = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
  spi_state_t state_q, state_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [IO_COUNT-1:0] shreg_q, shreg_d, data_q, data_d;
  logic sbit_q, sbit_d, sdo_q, sdo_d, sck_q, sck_d, nss_q, nss_d;
  logic busy_q, busy_d, done_q, done_d;
  logic tick, accept, edge_ev, lead, shift_ev, smp_ev, smp_now, sdi_s;
  spi_sck_tick #(.DIV(DIV)) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q != IDLE),
    .clr_i (state_q == IDLE),
    .tick_o(tick)
  );
  assign accept   = state_q == IDLE && start_i;
  assign edge_ev  = tick && (state_q == SETUP || (state_q == SHIFT && hc_q != HLAST));
  assign lead     = sck_q == POL;
  assign shift_ev = edge_ev && (lead == PHA);
  assign smp_ev   = edge_ev && (lead != PHA);
`ifdef SPI_MASTER_SDI_SYNC_EN
  logic [1:0] sync_q, smp_q;
  if (DIV < 3) begin : g_div_chk
    $error("spi_master: SPI_MASTER_SDI_SYNC_EN requires DIV >= 3");
  end
  // synchronize sdi_i and delay the sample strobe by the same two cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      smp_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], sdi_i};
      smp_q  <= {smp_q[0], smp_ev};
    end
  end
  assign smp_now = smp_q[1];
  assign sdi_s   = sync_q[1];
`else
  assign smp_now = smp_ev;
  assign sdi_s   = sdi_i;
`endif
  // next-state: frame sequencing, SCK edges, shift/sample datapath and registered outputs
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    shreg_d = shreg_q;
    sbit_d  = smp_now ? sdi_s : sbit_q;
    sdo_d   = sdo_q;
    sck_d   = edge_ev ? ~sck_q : sck_q;
    done_d  = tick && state_q == HOLD;
    data_d  = done_d ? shreg_q : data_q;
    if (accept) begin
      state_d = SETUP;
      shreg_d = data_i;
      sdo_d   = data_i[IO_COUNT-1];
    end
    if (shift_ev) begin
      shreg_d = {shreg_q[IO_COUNT-2:0], PHA ? 1'b0 : sbit_q};
      sdo_d   = PHA ? shreg_q[IO_COUNT-1] : shreg_q[IO_COUNT-2];
    end
    if (smp_now && PHA) shreg_d[0] = sdi_s;
    if (tick) begin
      hc_d = state_q == SHIFT ? hc_q + 1'b1 : '0;
      case (state_q)
        SETUP:   state_d = SHIFT;
        SHIFT:   state_d = hc_q == HLAST ? HOLD : SHIFT;
        HOLD:    state_d = GAP;
        default: state_d = IDLE;
      endcase
    end
    nss_d  = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    busy_d = state_d != IDLE;
  end
  // FSM and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hc_q    <= '0;
      shreg_q <= '0;
      sbit_q  <= 1'b0;
      sdo_q   <= 1'b0;
      sck_q   <= POL;
      nss_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      shreg_q <= shreg_d;
      sbit_q  <= sbit_d;
      sdo_q   <= sdo_d;
      sck_q   <= sck_d;
      nss_q   <= nss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end
  assign data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign nss_o  = nss_q;
  assign sck_o  = sck_q;
  assign sdo_o  = sdo_q;
endmodule
